// File: rtl/sram_tile_streamer.sv
// stream_fifo: small generic synchronous FIFO with registered head.
// Latency: a word pushed at edge N is visible on pop_data after edge N.
// Backpressure: the caller must not push when full unless it pops in the same cycle.
//   Ports: push/push_data write side, pop/pop_data read side, count and not_empty status.
module stream_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         not_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign pop_data  = mem[rd_ptr];
    assign not_empty = (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CW'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == '0)));
endmodule

// sram_tile_streamer: reads len consecutive SRAM words from base_addr and streams them out.
// Latency: start at E0, first read issued at E1, first beat valid after E2, done after E(len+2).
// Backpressure: m_ready=0 stops issue once 2 words are buffered/in flight; nothing is lost.
//   Ports: start/base_addr/len launch, busy/done status, sram_raddr/sram_rdata to the SRAM,
//   m_valid/m_ready/m_data/m_last output stream.
module sram_tile_streamer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   beats_sent;
    logic              inflight;
    logic              start_ok;
    logic              issue;
    logic              pop;
    logic              last_beat;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;

    assign start_ok  = (state == S_IDLE) && start;
    assign pop       = m_valid & m_ready;
    assign last_beat = (beats_sent == (len_q - LEN_ONE));

    // Words buffered plus the one possibly in the SRAM pipe; a pop this cycle frees a slot,
    // so issue can continue back-to-back while the consumer keeps accepting.
    assign occ   = {1'b0, fifo_count} + {2'b00, inflight};
    assign issue = (state == S_RUN) && (issued < len_q) && (occ < (3'd2 + {2'b00, pop}));

    // The SRAM samples raddr at the issuing edge, so the address is presented combinationally
    // during the issue cycle and held from a register otherwise.
    assign sram_raddr = issue ? (base_q + issued[ADDR_W-1:0]) : raddr_q;

    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign m_last = m_valid & last_beat;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            raddr_q    <= '0;
            issued     <= '0;
            beats_sent <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Read data returns one cycle after issue and is pushed that same edge.
            inflight <= issue;
            if (start_ok) begin
                base_q     <= base_addr;
                len_q      <= len;
                issued     <= '0;
                beats_sent <= '0;
            end else begin
                if (issue) begin
                    issued  <= issued + LEN_ONE;
                    raddr_q <= sram_raddr;
                end
                if (pop) begin
                    beats_sent <= beats_sent + LEN_ONE;
                end
            end
        end
    end

    stream_fifo #(
        .W     (DATA_W),
        .DEPTH (2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (sram_rdata),
        .pop       (pop),
        .pop_data  (m_data),
        .count     (fifo_count),
        .not_empty (m_valid)
    );
endmodule

// File: tb/tb_sram_tile_streamer.sv
// Testbench for sram_tile_streamer: SRAM behavioural model, scoreboard of expected beats
// derived from (base + i) mod depth, and a negedge monitor comparing every handshake.
module tb_sram_tile_streamer;
    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    sram_tile_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    // Read-first, 1-cycle registered-read SRAM.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) sram_rdata <= mem[sram_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] exp_data [$];
    bit            exp_last [$];

    int  beats_rcv;
    int  done_count;
    int  done_cyc;
    int  first_valid_cyc;
    bit  busy_seen;
    int  ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream acceptance pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    initial begin
        int pat_i;
        pat_i   = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (pat_i == 0);
                    pat_i   = (pat_i + 1) % 3;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard consumer.
    initial begin
        bit            hold_prev;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [DW-1:0] d;
        bit            l;
        hold_prev = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (busy) busy_seen = 1'b1;
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                    check("busy_low_at_done", busy, 0);
                end
                if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (!m_valid) check("last_unqualified", m_last, 0);
                if (hold_prev) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                    check("hold_last", m_last, prev_last);
                end
                if (m_valid && m_ready) begin
                    if (exp_data.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_beat: got data %0h, required no beat", m_data);
                    end else begin
                        d = exp_data.pop_front();
                        l = exp_last.pop_front();
                        check("beat_data", m_data, d);
                        check("beat_last", m_last, l);
                        beats_rcv++;
                    end
                end
                hold_prev = m_valid && !m_ready;
                prev_data = m_data;
                prev_last = m_last;
            end
        end
    end

    task automatic do_xfer(input int b, input int l, input int mode, input bit timing,
                           input bit intrude);
        int st;
        int budget;
        int waited;
        ready_mode = mode;
        for (int i = 0; i < l; i++) begin
            exp_data.push_back(mem[(b + i) % DEPTH]);
            exp_last.push_back(i == l - 1);
        end
        done_count      = 0;
        first_valid_cyc = -1;
        busy_seen       = 1'b0;
        beats_rcv       = 0;
        start     = 1'b1;
        base_addr = AW'(b);
        len       = (AW + 1)'(l);
        @(posedge clk);
        #1;
        st        = cyc;
        start     = 1'b0;
        base_addr = AW'($urandom);
        len       = (AW + 1)'($urandom);
        if (intrude) begin
            repeat (3) @(posedge clk);
            #1;
            start     = 1'b1;
            base_addr = AW'(b + 100);
            len       = (AW + 1)'(5);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        budget = 4 * l + 40;
        waited = 0;
        while (done_count == 0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (done_count == 0) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: no done within %0d cycles (len %0d)", budget, l);
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_count, 1);
        check("beats_all", beats_rcv, l);
        check("exp_q_empty", exp_data.size(), 0);
        if (timing) begin
            check("done_latency", done_cyc - st, (l == 0) ? 0 : l + 2);
            if (l > 0) check("first_valid_latency", first_valid_cyc - st, 2);
        end
        if (l == 0) begin
            check("len0_no_valid", (first_valid_cyc < 0), 1);
            check("len0_no_busy", busy_seen, 0);
        end
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_raddr"}, sram_raddr, 0);
    endtask

    task automatic reset_mid_xfer(input int b);
        int waited;
        ready_mode = 0;
        for (int i = 0; i < 8; i++) begin
            exp_data.push_back(mem[(b + i) % DEPTH]);
            exp_last.push_back(i == 7);
        end
        beats_rcv  = 0;
        done_count = 0;
        start      = 1'b1;
        base_addr  = AW'(b);
        len        = (AW + 1)'(8);
        @(posedge clk);
        #1;
        start  = 1'b0;
        waited = 0;
        while (beats_rcv < 3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_beats_before", (beats_rcv >= 3 && beats_rcv < 8), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_data.delete();
        exp_last.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", done_count, 0);
        check("rst_mid_idle_valid", m_valid, 0);
        check("rst_mid_idle_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {32'($urandom), 32'(i)};
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        do_xfer(5, 4, 0, 1'b1, 1'b0);                     // basic, back-to-back beats
        do_xfer(DEPTH - 2, 4, 0, 1'b1, 1'b0);             // address wrap
        do_xfer(int'($urandom_range(0, DEPTH - 1)), 8, 1, 1'b0, 1'b0); // 1,0,0 stall pattern
        do_xfer(17, 0, 0, 1'b1, 1'b0);                    // zero length
        do_xfer(100, 8, 0, 1'b1, 1'b1);                   // start while busy ignored
        reset_mid_xfer(300);
        do_xfer(200, 6, 0, 1'b1, 1'b0);                   // clean run after reset
        for (int k = 0; k < 8; k++) begin
            do_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2,
                    1'b0, 1'b0);
        end
        do_xfer(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 1'b1, 1'b0); // full depth

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
